dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter sharing the single data memory between the pipeline's memory-access stage (port 0) and a secondary master such as a debug/program loader (port 1). It grants at most one access per cycle, drives the memory's address, width, write-enable and write-data, and returns registered read data to the winning port one cycle later. Requesters may lock the memory for back-to-back accesses, bounded by a lock timeout.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_LOCK, 8, maximum consecutive grants to a locked owner before forced release; legal range 1..255.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pN_req  in  1  port N (N=0,1) requests an access this cycle.
- pN_lock  in  1  port N wants to keep ownership after this access.
- pN_addr  in  ADDR_W  access address.
- pN_we  in  1  1 = store, 0 = load.
- pN_wdata  in  DATA_W  store data.
- pN_width  in  3  funct3-style access width, passed to memory unchanged.
- pN_gnt  out  1  combinational; access accepted this cycle.
- pN_rvalid  out  1  registered; pN_rdata valid (loads only).
- pN_rdata  out  DATA_W  registered load data.
- mem_addr  out  ADDR_W  to data memory.
- mem_width  out  3  to data memory.
- mem_we  out  1  to data memory; high only when a granted store.
- mem_wdata  out  DATA_W  to data memory.
- mem_rdata  in  DATA_W  combinational read data from memory.

## Operation
- States: IDLE, OWN0, OWN1. Reset: IDLE, last-winner = 1, lock counter = 0.
- IDLE: if only one port requests, grant it. If both request, grant the port that is not last-winner (round robin). Granting port N with pN_lock=1 enters OWNN and loads counter = 1; otherwise stays IDLE.
- OWNN: only port N may be granted; other port's gnt is 0. If pN_req=1: grant, increment counter. Return to IDLE when pN_lock=0 on a granted access, when pN_req=0 for a cycle, or when counter reaches MAX_LOCK (that access is still granted). Last-winner updated to N on every grant.
- Mux: mem_* driven from the granted port; with no grant, mem_we=0 and mem_addr/mem_wdata/mem_width from port 0 (don't-care but stable).
- Loads: on a granted load, mem_rdata is captured into the winner's rdata register and pN_rvalid=1 next cycle only. Stores never assert rvalid. rdata holds its value until the next load to that port.
- pN_lock ignored when pN_req=0.

## Timing
- Grant: zero latency, combinational from req/lock/state.
- Read data: exactly 1 cycle after grant.
- Throughput: one access per cycle total.
- A non-granted requester must hold req and its request fields stable until granted.
- Reset values: pN_gnt=0, pN_rvalid=0, pN_rdata=0, mem_we=0. Reset asserted mid-lock returns to IDLE immediately; any pending rvalid is dropped.
- Forced release at MAX_LOCK: next cycle is IDLE with last-winner = N, so a waiting other port wins.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin tie-break as above.
- Undefined: fixed priority, port 0 always wins ties in IDLE; last-winner register is absent; locking and MAX_LOCK behaviour unchanged.

## Test plan
- Single load: p0_req=1, we=0, addr=0x10, mem_rdata=0xDEADBEEF -> p0_gnt=1 same cycle, p0_rvalid=1 and p0_rdata=0xDEADBEEF next cycle, p1 signals 0.
- Contention, RR: both request loads for 4 cycles from reset -> grants alternate p0, p1, p0, p1; without DMEM_ARB_RR_EN all four go to p0.
- Lock: p1 requests 3 stores with lock=1,1,0 while p0 requests continuously -> p1 granted 3 consecutive cycles, then p0 granted; mem_we=1 only during p1 grants.
- Lock timeout, MAX_LOCK=8: p0 holds req and lock for 12 cycles, p1 requesting -> p0 granted cycles 1-8, p1 granted cycle 9.
- Reset mid-lock: assert rst while in OWN1 with a load granted -> p1_rvalid=0, p1_rdata=0, state IDLE; first post-reset contention grants p0.
- Store no response: granted store from p0 -> p0_rvalid stays 0, prior p0_rdata unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with lockable ownership and registered read return.
// Optional DMEM_ARB_RR_EN: round-robin tie-break in IDLE (fixed port-0 priority otherwise).
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [2:0]        p0_width,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [2:0]        p1_width,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_width,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);
    // With MAX_LOCK of 1 the first locked grant already exhausts the budget.
    localparam bit         LOCK_EN    = (MAX_LOCK > 1);

    state_t      state_reg, state_next;
    logic [7:0]  lock_cnt_reg, lock_cnt_next;
    logic [7:0]  cnt_inc;
    logic        gnt0_c, gnt1_c;
    logic        tie_to_p1;
    logic [1:0]  gnt_v, we_v;
    logic [1:0]  rvalid_reg;
    logic [DATA_W-1:0] rdata_reg [2];

`ifdef DMEM_ARB_RR_EN
    logic last_winner_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_winner_reg <= 1'b1;
        else if (gnt1_c)
            last_winner_reg <= 1'b1;
        else if (gnt0_c)
            last_winner_reg <= 1'b0;
    end

    assign tie_to_p1 = ~last_winner_reg;
`else
    assign tie_to_p1 = 1'b0;
`endif

    assign cnt_inc = lock_cnt_reg + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            lock_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    always_comb begin
        gnt0_c        = 1'b0;
        gnt1_c        = 1'b0;
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (p0_req && !(p1_req && tie_to_p1)) begin
                    gnt0_c = 1'b1;
                    if (p0_lock && LOCK_EN) begin
                        state_next    = OWN0;
                        lock_cnt_next = 8'd1;
                    end
                end else if (p1_req) begin
                    gnt1_c = 1'b1;
                    if (p1_lock && LOCK_EN) begin
                        state_next    = OWN1;
                        lock_cnt_next = 8'd1;
                    end
                end
            end
            OWN0: begin
                if (p0_req) begin
                    gnt0_c        = 1'b1;
                    lock_cnt_next = cnt_inc;
                    if (!p0_lock || cnt_inc >= MAX_LOCK_C) begin
                        state_next    = IDLE;
                        lock_cnt_next = 8'd0;
                    end
                end else begin
                    state_next    = IDLE;
                    lock_cnt_next = 8'd0;
                end
            end
            OWN1: begin
                if (p1_req) begin
                    gnt1_c        = 1'b1;
                    lock_cnt_next = cnt_inc;
                    if (!p1_lock || cnt_inc >= MAX_LOCK_C) begin
                        state_next    = IDLE;
                        lock_cnt_next = 8'd0;
                    end
                end else begin
                    state_next    = IDLE;
                    lock_cnt_next = 8'd0;
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = 8'd0;
            end
        endcase
    end

    // Grants are suppressed while reset is held so nothing reaches memory.
    assign p0_gnt = gnt0_c & ~rst;
    assign p1_gnt = gnt1_c & ~rst;

    assign mem_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign mem_width = p1_gnt ? p1_width : p0_width;
    assign mem_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign mem_we    = (p0_gnt & p0_we) | (p1_gnt & p1_we);

    assign gnt_v = {p1_gnt, p0_gnt};
    assign we_v  = {p1_we, p0_we};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= gnt_v[gi] & ~we_v[gi];
                    if (gnt_v[gi] && !we_v[gi])
                        rdata_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign p0_rvalid = rvalid_reg[0];
    assign p1_rvalid = rvalid_reg[1];
    assign p0_rdata  = rdata_reg[0];
    assign p1_rdata  = rdata_reg[1];

endmodule
